// File: rtl/mioc_dma_arbiter.sv
// mioc_dma_arbiter
// Hands the ADAM system bus from the Z80 to the master 6801 for DMA into DRAM.
// Runs the BUSRQ_N/BUSAK_N handshake, takes the Z80 address buffers off the
// bus, grants the 6801 through IS3_N, and hands the bus back in reverse order.
// A shared counter provides the bus-settle holdoffs and the BUSAK_N watchdog.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | Z80 owns the bus, waiting for a DMA request outside refresh
// REQ      | BUSRQ_N asserted, waiting for BUSAK_N (watchdog running)
// SETTLE   | Z80 buffers disabled, letting the bus settle before grant
// GRANT    | 6801 owns the bus (IS3_N low) until its request drops
// UNSETTLE | grant removed, letting the bus settle before buffers return
// RELWAIT  | BUSRQ_N released, waiting for BUSAK_N high (watchdog running)

module mioc_dma_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int CNT_W          = 8
) (
  input  logic i_b_phi,
  input  logic i_rst_n,
  input  logic i_dma_n,
  input  logic i_busak_n,
  input  logic i_brfsh_n,
  output logic o_busrq_n,
  output logic o_addrbufen_n,
  output logic o_is3_n,
  output logic o_dma_active,
  output logic o_timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_SETTLE   = 3'd2,
    S_GRANT    = 3'd3,
    S_UNSETTLE = 3'd4,
    S_RELWAIT  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HO_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_err_set;

  logic r_sync1;
  logic r_sync2;
  logic w_dma_req;

  logic r_busrq_n;
  logic r_addrbufen_n;
  logic r_is3_n;
  logic r_dma_active;
  logic r_timeout_err;

  logic w_busrq_nxt;
  logic w_addrbufen_nxt;
  logic w_is3_nxt;
  logic w_dma_active_nxt;

  // DMA_N comes from the 6801 clock domain; two flops before the FSM sees it
  always_ff @(posedge i_b_phi or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_dma_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_dma_req = ~r_sync2;

  // Counter holds at all-ones so a stuck handshake can never wrap it back to a short count
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  // State register, counter and sticky watchdog flag
  always_ff @(posedge i_b_phi or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_timeout_err <= r_timeout_err | w_err_set;
    end
  end

  // Next-state and counter decisions; every state change restarts the counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Refresh only defers the start; once in REQ the Z80 sorts refresh out itself
        if (w_dma_req && i_brfsh_n) begin
          w_state_nxt = S_REQ;
          w_cnt_nxt   = '0;
        end
      end
      S_REQ: begin
        if (!w_dma_req) begin
          w_state_nxt = S_RELWAIT;
          w_cnt_nxt   = '0;
        end else if (!i_busak_n) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= C_TO_LAST) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_RELWAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_SETTLE: begin
        if (r_cnt >= C_HO_LAST) begin
          w_state_nxt = S_GRANT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_GRANT: begin
        if (!w_dma_req) begin
          w_state_nxt = S_UNSETTLE;
          w_cnt_nxt   = '0;
        end
      end
      S_UNSETTLE: begin
        if (r_cnt >= C_HO_LAST) begin
          w_state_nxt = S_RELWAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_RELWAIT: begin
        if (i_busak_n) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= C_TO_LAST) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pin levels decoded from the state being entered, so the registered pins
  // change on the same edge as the state. Grant is only ever decoded inside
  // the buffers-off / bus-requested window.
  always_comb begin
    w_busrq_nxt      = 1'b1;
    w_addrbufen_nxt  = 1'b0;
    w_is3_nxt        = 1'b1;
    w_dma_active_nxt = 1'b0;
    case (w_state_nxt)
      S_REQ: begin
        w_busrq_nxt = 1'b0;
      end
      S_SETTLE, S_UNSETTLE: begin
        w_busrq_nxt      = 1'b0;
        w_addrbufen_nxt  = 1'b1;
        w_dma_active_nxt = 1'b1;
      end
      S_GRANT: begin
        w_busrq_nxt      = 1'b0;
        w_addrbufen_nxt  = 1'b1;
        w_is3_nxt        = 1'b0;
        w_dma_active_nxt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Registered pins; reset puts the Z80 back on the bus without waiting for a clock
  always_ff @(posedge i_b_phi or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busrq_n     <= 1'b1;
      r_addrbufen_n <= 1'b0;
      r_is3_n       <= 1'b1;
      r_dma_active  <= 1'b0;
    end else begin
      r_busrq_n     <= w_busrq_nxt;
      r_addrbufen_n <= w_addrbufen_nxt;
      r_is3_n       <= w_is3_nxt;
      r_dma_active  <= w_dma_active_nxt;
    end
  end

  assign o_busrq_n     = r_busrq_n;
  assign o_addrbufen_n = r_addrbufen_n;
  assign o_is3_n       = r_is3_n;
  assign o_dma_active  = r_dma_active;
  assign o_timeout_err = r_timeout_err;

endmodule
